// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues JK commands and replays each as a registered j/k pair for cmd_len cycles,
// tracking the expected downstream flop output in q_exp.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [LEN_W-1:0]         cmd_len,
  output logic                     j,
  output logic                     k,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     q_exp
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] rem_q, rem_d, head_len;
  logic [1:0] jk_q, jk_d, head_op;
  logic done_q, done_d, q_exp_q, q_exp_d;
  logic push, load, finish;
  logic [LEN_W+1:0] mem_q [DEPTH];
  assign cmd_ready = cnt_q != (AW+1)'(DEPTH);
  assign {head_op, head_len} = mem_q[rd_q];
  assign push = cmd_valid & cmd_ready & ~flush;
  assign finish = (state_q == RUN) & (rem_q == LEN_W'(1));
  assign load = ~flush & (cnt_q != '0) & ((state_q == IDLE) | finish);
  always_comb begin
    wr_d = flush ? '0 : wr_q + AW'(push);
    rd_d = flush ? '0 : rd_q + AW'(load);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(load);
    jk_d = flush ? 2'b00 : load ? (head_len != '0 ? head_op : 2'b00) : finish ? 2'b00 : jk_q;
    rem_d = flush ? '0 : load ? head_len : (state_q == RUN) ? rem_q - 1'b1 : rem_q;
    state_d = flush ? IDLE : load ? (head_len != '0 ? RUN : IDLE) : finish ? IDLE : state_q;
    done_d = ~flush & (finish | (load & (head_len == '0)));
    q_exp_d = jk_q == 2'b01 ? 1'b0 : jk_q == 2'b10 ? 1'b1 : jk_q == 2'b11 ? ~q_exp_q : q_exp_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      rem_q <= '0;
      jk_q <= 2'b00;
      done_q <= 1'b0;
      q_exp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      jk_q <= jk_d;
      done_q <= done_d;
      q_exp_q <= q_exp_d;
    end
  end
  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {cmd_op, cmd_len};
  end
  assign {j, k} = jk_q;
  assign busy = state_q == RUN;
  assign done = done_q;
  assign fifo_count = cnt_q;
  assign q_exp = q_exp_q;
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer: directed scenarios plus random traffic, checked every cycle against a queue-based model.
module tb_jk_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int LEN_W = 4;
  logic clk = 0, reset_n = 0, flush = 0, cmd_valid = 0;
  logic [1:0] cmd_op = 0;
  logic [LEN_W-1:0] cmd_len = 0;
  logic cmd_ready, j, k, busy, done, q_exp;
  logic [$clog2(DEPTH):0] fifo_count;
  int tests = 0, fails = 0;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .j(j), .k(k), .busy(busy), .done(done),
    .fifo_count(fifo_count), .q_exp(q_exp));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of pending commands and the number of cycles the current command still owns the outputs.
  typedef struct packed {logic [1:0] op; logic [LEN_W-1:0] len;} cmd_t;
  cmd_t mq[$];
  cmd_t c;
  int left = 0;
  logic [1:0] mjk = 0;
  logic mdone = 0, mq_exp = 0;
  bit can_push;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete(); left = 0; mjk = 0; mdone = 0; mq_exp = 0;
    end else begin
      can_push = cmd_valid && mq.size() < DEPTH;
      case (mjk)
        2'b01: mq_exp = 0;
        2'b10: mq_exp = 1;
        2'b11: mq_exp = ~mq_exp;
        default: ;
      endcase
      if (flush) begin
        mq.delete(); left = 0; mjk = 0; mdone = 0;
      end else begin
        mdone = (left == 1);
        if (left <= 1) begin
          if (mq.size() > 0) begin
            c = mq.pop_front();
            if (c.len == 0) begin mdone = 1; mjk = 0; left = 0; end
            else begin mjk = c.op; left = int'(c.len); end
          end else begin
            mjk = 0; left = 0;
          end
        end else left--;
        if (can_push) mq.push_back({cmd_op, cmd_len});
      end
    end
  end

  always @(negedge clk) begin
    chk("j", int'(j), int'(mjk[1]));
    chk("k", int'(k), int'(mjk[0]));
    chk("busy", int'(busy), int'(left > 0));
    chk("done", int'(done), int'(mdone));
    chk("q_exp", int'(q_exp), int'(mq_exp));
    chk("fifo_count", int'(fifo_count), mq.size());
    chk("cmd_ready", int'(cmd_ready), int'(mq.size() != DEPTH));
  end

  task automatic tick(); @(negedge clk); endtask

  task automatic push1(input logic [1:0] op, input int len);
    cmd_valid = 1; cmd_op = op; cmd_len = LEN_W'(len); tick(); cmd_valid = 0;
  endtask

  initial begin
    int n11, nd, peak, waited;
    repeat (3) tick();
    chk("rst_j", int'(j), 0); chk("rst_k", int'(k), 0); chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0); chk("rst_qexp", int'(q_exp), 0);
    chk("rst_count", int'(fifo_count), 0); chk("rst_ready", int'(cmd_ready), 1);
    reset_n = 1; tick();
    // set for 3 cycles
    push1(2'b10, 3);
    chk("s_cnt_e0", int'(fifo_count), 1); chk("s_j_e0", int'(j), 0);
    tick(); chk("s_j_e1", int'(j), 1); chk("s_k_e1", int'(k), 0); chk("s_busy_e1", int'(busy), 1);
    chk("s_cnt_e1", int'(fifo_count), 0);
    tick(); chk("s_qexp_e2", int'(q_exp), 1);
    tick(); chk("s_j_e3", int'(j), 1);
    tick(); chk("s_j_e4", int'(j), 0); chk("s_done_e4", int'(done), 1); chk("s_busy_e4", int'(busy), 0);
    tick(); chk("s_done_e5", int'(done), 0);
    // clear, then four back-to-back toggles
    push1(2'b01, 1); repeat (3) tick(); chk("c_qexp", int'(q_exp), 0);
    n11 = 0; nd = 0; peak = 0;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = i < 4; cmd_op = 2'b11; cmd_len = 1;
      tick();
      if (j && k) n11++;
      if (done) nd++;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    cmd_valid = 0;
    chk("t_jk11_cycles", n11, 4); chk("t_done_pulses", nd, 4); chk("t_peak", peak, 1);
    chk("t_qexp_end", int'(q_exp), 0);
    // long command holds the engine while the queue fills
    push1(2'b11, 15);
    for (int i = 0; i < 4; i++) push1(2'b10, 1);
    chk("f_full_cnt", int'(fifo_count), 4); chk("f_full_ready", int'(cmd_ready), 0);
    cmd_valid = 1; cmd_op = 2'b01; cmd_len = 2; waited = 0;
    while (!cmd_ready && waited < 40) begin tick(); waited++; end
    chk("f_ready_back", int'(cmd_ready), 1); chk("f_waited", int'(waited > 5), 1);
    tick(); cmd_valid = 0;
    repeat (20) tick();
    chk("f_drained", int'(fifo_count), 0);
    // zero-length command
    push1(2'b01, 0);
    chk("z_cnt_e0", int'(fifo_count), 1);
    tick(); chk("z_done", int'(done), 1); chk("z_j", int'(j), 0); chk("z_k", int'(k), 0);
    chk("z_busy", int'(busy), 0); chk("z_cnt", int'(fifo_count), 0);
    tick(); chk("z_done_off", int'(done), 0);
    // flush mid-run with two queued and a simultaneous push
    push1(2'b10, 10); push1(2'b11, 3); push1(2'b01, 3); tick();
    chk("fl_pre_cnt", int'(fifo_count), 2); chk("fl_pre_busy", int'(busy), 1);
    flush = 1; cmd_valid = 1; cmd_op = 2'b11; cmd_len = 2; tick(); flush = 0; cmd_valid = 0;
    chk("fl_j", int'(j), 0); chk("fl_k", int'(k), 0); chk("fl_busy", int'(busy), 0);
    chk("fl_cnt", int'(fifo_count), 0); chk("fl_done", int'(done), 0);
    tick(); chk("fl_done2", int'(done), 0); chk("fl_cnt2", int'(fifo_count), 0); chk("fl_j2", int'(j), 0);
    // asynchronous reset mid-run
    push1(2'b11, 8); push1(2'b10, 4); repeat (3) tick();
    @(posedge clk); #2 reset_n = 0; #1;
    chk("ar_j", int'(j), 0); chk("ar_k", int'(k), 0); chk("ar_busy", int'(busy), 0);
    chk("ar_cnt", int'(fifo_count), 0); chk("ar_qexp", int'(q_exp), 0); chk("ar_ready", int'(cmd_ready), 1);
    tick(); reset_n = 1; tick();
    push1(2'b10, 2); tick(); chk("ar_after_j", int'(j), 1); tick(); tick();
    chk("ar_after_qexp", int'(q_exp), 1); chk("ar_after_done", int'(done), 1);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cmd_valid = $urandom_range(0, 1);
      cmd_op = 2'($urandom_range(0, 3));
      cmd_len = $urandom_range(0, 3) == 0 ? LEN_W'($urandom_range(0, 15)) : LEN_W'($urandom_range(0, 3));
      flush = $urandom_range(0, 49) == 0;
      tick();
    end
    cmd_valid = 0; flush = 0;
    repeat (80) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
- Upstream driver stage for the JK flip-flop. It queues hold/clear/set/toggle commands from a valid/ready producer.
- Each command is replayed as a registered j/k pair for a programmed number of consecutive clock cycles.
- A shadow model of the downstream flop output (q_exp) is kept so a checker or controller can compare it against the real q without reading back.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of 2, minimum 2.
- LEN_W, 4, width of the per-command repeat length.

Ports:
- clk  input  1  rising-edge clock, shared with the downstream JK flop.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of the queue and the engine.
- cmd_valid  input  1  producer has a command.
- cmd_ready  output  1  command is accepted on the edge where valid & ready.
- cmd_op  input  2  {j,k} code: 00 hold, 01 clear, 10 set, 11 toggle.
- cmd_len  input  LEN_W  number of cycles to drive cmd_op.
- j  output  1  registered J to the flop.
- k  output  1  registered K to the flop.
- busy  output  1  engine is in RUN.
- done  output  1  one-cycle pulse when a command completes.
- fifo_count  output  clog2(DEPTH)+1  number of queued entries.
- q_exp  output  1  expected flop output after the current edge.

Behaviour:
- Reset (reset_n low, asynchronous) forces:
  - j=0, k=0, busy=0, done=0, q_exp=0, fifo_count=0.
  - cmd_ready=1, state IDLE, read/write pointers 0.
- Release of reset is sampled synchronously at the next clk edge.
- FIFO:
  - cmd_ready = (fifo_count != DEPTH). It is combinational from the count only.
  - A write happens on an edge with cmd_valid & cmd_ready. A pop happens on an edge where the engine loads.
  - Push and pop on the same edge leave fifo_count unchanged.
  - Full blocks a push even if a pop occurs on the same edge (no pass-through).
  - Pointers wrap modulo DEPTH.
- Engine states: IDLE, RUN. There is a remaining-cycles counter rem (LEN_W bits).
  - Load happens on an edge where the FIFO is non-empty and either the state is IDLE, or the state is RUN with rem==1.
    - Head entry is popped.
    - If len != 0: {j,k} <= op, rem <= len, state <= RUN.
    - If len == 0: entry is consumed, {j,k} <= 00, done <= 1, state <= IDLE. Zero-length commands emit nothing.
  - RUN with rem > 1: rem <= rem-1, j/k held.
  - RUN with rem==1 and FIFO empty: {j,k} <= 00, state <= IDLE.
  - Every edge where rem goes 1 -> complete asserts done for the following cycle, whether or not a back-to-back load occurs.
  - Back-to-back commands produce no 00 gap cycle.
- Latency: a command accepted at edge E0 into an empty FIFO with the engine IDLE loads at E1. j/k are valid from E1 to E1+len. The downstream flop samples them at edges E2..E1+len.
- q_exp:
  - Updated on every edge from the current j/k outputs using JK rules: 00 hold, 01 ->0, 10 ->1, 11 ->~q_exp.
  - It therefore matches the flop q cycle-for-cycle, provided the flop was cleared in the same cycle that reset_n deasserted.
- flush (synchronous) takes priority over all other actions:
  - Pointers and count go to 0, {j,k} <= 00, state IDLE, rem 0.
  - done <= 0 and no done pulse is produced.
  - Any push in the same cycle is discarded.
  - q_exp still updates from the j/k values present before the edge.
- Reset mid-RUN: asynchronous abort with outputs as at reset. The in-flight and queued commands are lost.
- busy = (state == RUN) and is registered.

Test Plan:
- Reset, then push op=10 len=3 at E0 -> j=1,k=0 during E1..E3; 00 from E4. done=1 in the cycle after E4. q_exp=1 after E2.
- Starting from q_exp=0, push four toggles (11, len 1) back-to-back -> j=k=1 continuous for 4 cycles with no gap. q_exp goes 1,0,1,0. done pulses 4 times. fifo_count peaks at the expected value.
- Hold cmd engine in RUN with len=15 and push 5 commands (DEPTH=4) -> the 5th waits with cmd_ready=0 until the first pop. No command is lost or duplicated.
- Push op=01 len=0 -> j/k stay 00, done pulses once, fifo_count returns to 0, busy stays 0.
- Assert flush mid-RUN with 2 entries queued -> next cycle j=k=0, busy=0, fifo_count=0, no done pulse. A simultaneous push is dropped.
- Drop reset_n asynchronously between edges during RUN -> outputs clear immediately. After release, a fresh command executes normally.
